// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source one-entry holding buffers drained oldest-first
// onto a single registered register-file write port.
module wb_arbiter #(
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned DW      = 32,
   parameter int unsigned AW      = 5,
   parameter int unsigned DROP_R0 = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_SRC-1:0]     src_valid,
   output logic [NUM_SRC-1:0]     src_ready,
   input  logic [NUM_SRC*AW-1:0]  src_dest,
   input  logic [NUM_SRC*DW-1:0]  src_val,
   output logic                   writeEn,
   output logic [AW-1:0]          dest,
   output logic [DW-1:0]          writeVal,
   output logic                   busy
);

   logic [NUM_SRC-1:0]              buf_full;
   logic [AW-1:0]                   buf_dest [NUM_SRC];
   logic [DW-1:0]                   buf_val  [NUM_SRC];
   // older[j][i] = 1: entry j arrived before entry i
   logic [NUM_SRC-1:0][NUM_SRC-1:0] older;

   logic [NUM_SRC-1:0] blocked;
   logic [NUM_SRC-1:0] grant;
   logic [NUM_SRC-1:0] load;
   logic               any_grant;
   logic [AW-1:0]      g_dest;
   logic [DW-1:0]      g_val;

   // An entry is granted when no full entry is older than it
   always_comb begin
      blocked = '0;
      grant   = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         for (int unsigned j = 0; j < NUM_SRC; j++) begin
            if (buf_full[j] && older[j][i]) blocked[i] = 1'b1;
         end
         grant[i] = buf_full[i] && !blocked[i];
      end
   end

   // Grant is one-hot, so an OR-mux selects the granted entry
   always_comb begin
      g_dest = '0;
      g_val  = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) begin
            g_dest = g_dest | buf_dest[i];
            g_val  = g_val  | buf_val[i];
         end
      end
   end

   assign any_grant = |grant;
   assign src_ready = ~buf_full | grant;
   assign load      = src_valid & src_ready;
   assign busy      = (|buf_full) || writeEn;

   // Occupancy, age matrix and write port
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_full <= '0;
         older    <= '0;
         writeEn  <= 1'b0;
         dest     <= '0;
         writeVal <= '0;
      end else begin
         writeEn <= any_grant && !((DROP_R0 != 0) && (g_dest == '0));
         if (any_grant) begin
            dest     <= g_dest;
            writeVal <= g_val;
         end
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
               buf_full[i] <= 1'b0;
               older[i]    <= '0;
            end
         end
         // Column writes follow row clears so a refilled slot gets fresh age
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (load[i]) begin
               buf_full[i] <= 1'b1;
               for (int unsigned j = 0; j < NUM_SRC; j++) begin
                  older[j][i] <= (buf_full[j] && !grant[j]) || (load[j] && (j < i));
               end
            end
         end
      end
   end

   // Payload storage needs no reset; it is qualified by buf_full
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (load[i]) begin
            buf_dest[i] <= src_dest[i*AW +: AW];
            buf_val[i]  <= src_val[i*DW +: DW];
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised bench for wb_arbiter: an arrival-ordered queue predicts every write,
// stall and busy flag for a DROP_R0=0 and a DROP_R0=1 instance sharing stimulus.
module tb_wb_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic              clk;
   logic              rst;
   logic [N-1:0]      src_valid;
   logic [N*AW-1:0]   src_dest;
   logic [N*DW-1:0]   src_val;
   logic [N-1:0]      rdy0, rdy1;
   logic              we0, we1;
   logic [AW-1:0]     dest0, dest1;
   logic [DW-1:0]     wval0, wval1;
   logic              busy0, busy1;

   wb_arbiter #(.NUM_SRC(N), .DW(DW), .AW(AW), .DROP_R0(0)) u_dut (
      .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(rdy0),
      .src_dest(src_dest), .src_val(src_val), .writeEn(we0), .dest(dest0),
      .writeVal(wval0), .busy(busy0));

   wb_arbiter #(.NUM_SRC(N), .DW(DW), .AW(AW), .DROP_R0(1)) u_drop (
      .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(rdy1),
      .src_dest(src_dest), .src_val(src_val), .writeEn(we1), .dest(dest1),
      .writeVal(wval1), .busy(busy1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            src;
      logic [AW-1:0] d;
      logic [DW-1:0] v;
   } ent_t;

   ent_t          q[$];
   logic          exp_we0, exp_we1;
   logic [AW-1:0] exp_dest;
   logic [DW-1:0] exp_val;
   int            n_tests = 0;
   int            n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit occ(input int s);
      foreach (q[k]) if (q[k].src == s) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_outputs();
      check("we",     64'(we0),   64'(exp_we0));
      check("we_d",   64'(we1),   64'(exp_we1));
      check("dest",   64'(dest0), 64'(exp_dest));
      check("dest_d", 64'(dest1), 64'(exp_dest));
      check("val",    64'(wval0), 64'(exp_val));
      check("val_d",  64'(wval1), 64'(exp_val));
      check("busy",   64'(busy0), 64'((q.size() != 0) || exp_we0));
      check("busy_d", 64'(busy1), 64'((q.size() != 0) || exp_we1));
   endtask

   // One clock: apply inputs, predict the edge from arrival order, check after it
   task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] d, input logic [N*DW-1:0] x);
      logic [N-1:0] rdy;
      ent_t e;
      src_valid = v;
      src_dest  = d;
      src_val   = x;
      #1;
      for (int i = 0; i < int'(N); i++)
         rdy[i] = !occ(i) || (q.size() != 0 && q[0].src == i);
      check("ready",   64'(rdy0), 64'(rdy));
      check("ready_d", 64'(rdy1), 64'(rdy));
      if (q.size() != 0) begin
         e        = q.pop_front();
         exp_we0  = 1'b1;
         exp_we1  = (e.d != '0);
         exp_dest = e.d;
         exp_val  = e.v;
      end else begin
         exp_we0 = 1'b0;
         exp_we1 = 1'b0;
      end
      for (int i = 0; i < int'(N); i++) begin
         if (v[i] && rdy[i]) begin
            e.src = i;
            e.d   = d[i*AW +: AW];
            e.v   = x[i*DW +: DW];
            q.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step('0, '0, '0);
   endtask

   task automatic do_reset(input int cycles);
      rst       = 1'b1;
      src_valid = '1;
      src_dest  = {N{AW'(3)}};
      src_val   = {N{32'h1234_5678}};
      for (int k = 0; k < cycles; k++) @(posedge clk);
      @(negedge clk);
      rst       = 1'b0;
      src_valid = '0;
      q.delete();
      exp_we0  = 1'b0;
      exp_we1  = 1'b0;
      exp_dest = '0;
      exp_val  = '0;
      #1;
      check_outputs();
      check("rst_ready",   64'(rdy0), 64'({N{1'b1}}));
      check("rst_ready_d", 64'(rdy1), 64'({N{1'b1}}));
   endtask

   initial begin
      logic [N-1:0]    v;
      logic [N*AW-1:0] d;
      logic [N*DW-1:0] x;
      rst       = 1'b1;
      src_valid = '0;
      src_dest  = '0;
      src_val   = '0;
      @(negedge clk);
      do_reset(2);

      // single result, one cycle of latency through the output register
      step(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hDEAD_BEEF});
      check("single_early", 64'(we0), 64'(0));
      step('0, '0, '0);
      check("single_dest", 64'(dest0), 64'(5));
      check("single_val",  64'(wval0), 64'(32'hDEAD_BEEF));
      idle(2);

      // simultaneous arrivals drain lowest index first
      step(3'b111, {5'd3, 5'd2, 5'd1}, {32'd3, 32'd2, 32'd1});
      step(3'b111, {5'd9, 5'd9, 5'd9}, {32'd9, 32'd9, 32'd9});
      idle(5);

      // same destination from two units keeps arrival order
      step(3'b111, {5'd7, 5'd2, 5'd1}, {32'hAAAA_0001, 32'd2, 32'd1});
      step(3'b001, {5'd0, 5'd0, 5'd7}, {32'd0, 32'd0, 32'hBBBB_0002});
      idle(5);

      // back-to-back on one source
      for (int k = 0; k < 8; k++)
         step(3'b010, {5'd0, 5'(k + 1), 5'd0}, {32'd0, 32'(100 + k), 32'd0});
      idle(2);

      // reset with buffers occupied discards everything
      step(3'b111, {5'd4, 5'd0, 5'd6}, {32'd40, 32'd41, 32'd42});
      do_reset(1);
      idle(3);

      // dest 0 on the dropping instance still takes its turn
      step(3'b011, {5'd0, 5'd8, 5'd0}, {32'd0, 32'd80, 32'd81});
      idle(4);

      for (int k = 0; k < 1500; k++) begin
         v = N'($urandom_range(0, (1 << N) - 1));
         for (int i = 0; i < int'(N); i++) begin
            d[i*AW +: AW] = AW'($urandom_range(0, 3));
            x[i*DW +: DW] = $urandom();
         end
         if ($urandom_range(0, 199) == 0) do_reset(1);
         else step(v, d, x);
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
